// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: dmem handshake, store lane alignment, load extraction, registered writeback.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses are trapped (ma_err/ma_addr) instead of issued.
module mem_stage #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic [1:0]  ex_mem_op,
    input  logic [2:0]  ex_funct3,
    input  logic [4:0]  ex_rd,
    input  logic        ex_rf_wen,
    mem_stage_if.master dmem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_rf_wen,
    output logic [31:0] wb_data,
    output logic        bus_err
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        ma_err,
    output logic [31:0] ma_addr
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        rf_wen_q, rf_wen_d;
    logic [31:0] cnt_q, cnt_d;
    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_rf_wen_q, wb_rf_wen_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        bus_err_q, bus_err_d;
`ifdef MISALIGN_TRAP_EN
    logic        ma_err_q, ma_err_d;
    logic [31:0] ma_addr_q, ma_addr_d;
`endif

    logic        accept, is_load, is_store, misalign, timeout_hit;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;

    assign accept      = ex_valid && ex_ready;
    assign is_load     = (ex_mem_op == 2'b01);
    assign is_store    = (ex_mem_op == 2'b10);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == ACK_TIMEOUT);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (is_load || is_store) &&
        ((((ex_funct3 == 3'b001) || (is_load && ex_funct3 == 3'b101)) && ex_alu_out[0]) ||
         ((ex_funct3 == 3'b010) && (ex_alu_out[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        st_wdata = ex_rs2_data;
        st_be    = 4'b0000;
        case (ex_funct3)
            3'b000: begin
                st_wdata = {4{ex_rs2_data[7:0]}};
                st_be    = 4'b0001 << ex_alu_out[1:0];
            end
            3'b001: begin
                st_wdata = {2{ex_rs2_data[15:0]}};
                st_be    = 4'b0011 << {ex_alu_out[1], 1'b0};
            end
            3'b010: st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = dmem.dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
        h = dmem.dmem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  ld_data = {{24{b[7]}}, b};
            3'b100:  ld_data = {24'h0, b};
            3'b001:  ld_data = {{16{h[15]}}, h};
            3'b101:  ld_data = {16'h0, h};
            default: ld_data = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            rd_q        <= '0;
            rf_wen_q    <= 1'b0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_rf_wen_q <= 1'b0;
            wb_data_q   <= '0;
            bus_err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            ma_err_q    <= 1'b0;
            ma_addr_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            rd_q        <= rd_d;
            rf_wen_q    <= rf_wen_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_rf_wen_q <= wb_rf_wen_d;
            wb_data_q   <= wb_data_d;
            bus_err_q   <= bus_err_d;
`ifdef MISALIGN_TRAP_EN
            ma_err_q    <= ma_err_d;
            ma_addr_q   <= ma_addr_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        we_d        = we_q;
        f3_d        = f3_q;
        rd_d        = rd_q;
        rf_wen_d    = rf_wen_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_rf_wen_d = wb_rf_wen_q;
        wb_data_d   = wb_data_q;
        bus_err_d   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        ma_err_d    = 1'b0;
        ma_addr_d   = ma_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((is_load || is_store) && !misalign) begin
                        state_d  = BUSY;
                        addr_d   = ex_alu_out;
                        wdata_d  = is_store ? st_wdata : '0;
                        be_d     = is_store ? st_be : 4'b1111;
                        we_d     = is_store;
                        f3_d     = ex_funct3;
                        rd_d     = ex_rd;
                        rf_wen_d = ex_rf_wen;
                        cnt_d    = '0;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_rd_d     = ex_rd;
                        wb_rf_wen_d = misalign ? 1'b0 : ex_rf_wen;
                        wb_data_d   = misalign ? '0 : ex_alu_out;
`ifdef MISALIGN_TRAP_EN
                        ma_err_d    = misalign;
                        if (misalign) ma_addr_d = ex_alu_out;
`endif
                    end
                end
            end
            BUSY: begin
                // A late ack takes priority over the timeout abort in the same cycle.
                if (dmem.dmem_ack) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_rf_wen_d = we_q ? 1'b0 : rf_wen_q;
                    wb_data_d   = we_q ? '0 : ld_data;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_rf_wen_d = 1'b0;
                    wb_data_d   = '0;
                    bus_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ex_ready        = (state_q == IDLE) && !rst;
        dmem.dmem_req   = (state_q == BUSY) && !timeout_hit;
        dmem.dmem_we    = (state_q == BUSY) ? we_q : 1'b0;
        dmem.dmem_addr  = (state_q == BUSY) ? {addr_q[31:2], 2'b00} : '0;
        dmem.dmem_wdata = (state_q == BUSY) ? wdata_q : '0;
        dmem.dmem_be    = (state_q == BUSY) ? be_q : '0;
        wb_valid        = wb_valid_q;
        wb_rd           = wb_rd_q;
        wb_rf_wen       = wb_rf_wen_q;
        wb_data         = wb_data_q;
        bus_err         = bus_err_q;
`ifdef MISALIGN_TRAP_EN
        ma_err          = ma_err_q;
        ma_addr         = ma_addr_q;
`endif
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute ALU.
- Consumes the ALU result (as a load/store address or a pass-through result) and the rs2 store data.
- Runs the data-memory request/acknowledge handshake, aligns store bytes, and extracts/sign-extends load data.
- Presents a registered writeback bundle to the register-file write port. Back-pressures execute while a memory access is outstanding.

Parameters:
- ACK_TIMEOUT, 0, max cycles spent in BUSY waiting for dmem_ack before aborting with bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ex_valid  in  1  execute presents an instruction.
- ex_ready  out  1  stage accepts; transfer when ex_valid && ex_ready.
- ex_alu_out  in  32  ALU result; the effective address for memory ops.
- ex_rs2_data  in  32  store data.
- ex_mem_op  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none).
- ex_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_rd  in  5  destination register.
- ex_rf_wen  in  1  register write enable.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  destination.
- wb_rf_wen  out  1  write enable.
- wb_data  out  32  writeback value.
- bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 and state IDLE, except ex_ready = 1 once rst deasserts.
- States:
  - IDLE: ex_ready = 1.
  - BUSY: ex_ready = 0; dmem_req = 1; dmem_we/addr/wdata/be driven from latched registers and stable until ack.
- Non-memory op accepted in IDLE:
  - Next cycle: wb_valid = 1, wb_data = ex_alu_out, wb_rd/wb_rf_wen copied.
  - State stays IDLE, giving back-to-back throughput of 1 per cycle.
- Memory op accepted in IDLE: latch address, data, funct3, rd and rf_wen; go to BUSY next cycle.
- BUSY with dmem_ack:
  - Next cycle: wb_valid = 1, back to IDLE.
  - Load: wb_data = extracted value. Store: wb_rf_wen = 0, wb_data = 0.
- Minimum memory latency: accept at cycle N, dmem_req at N+1, ack at N+1 gives wb_valid at N+2. ex_ready returns at N+2.
- wb_valid is 0 in every cycle not listed above. wb_* hold their last value when wb_valid = 0.
- Load extraction, with off = addr[1:0]:
  - B/BU: byte at off, sign- or zero-extended.
  - H/HU: halfword at addr[1], sign- or zero-extended.
  - W: the full word.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, be = 0001 << off.
  - SH: wdata = {2{rs2[15:0]}}, be = 0011 << (addr[1]*2).
  - SW: wdata = rs2, be = 1111.
- Load be: 1111.
- Undefined funct3 on a load is treated as W; on a store it gives be = 0000 (request still issued).
- Timeout counter:
  - Cleared on entry to BUSY; increments each BUSY cycle without ack.
  - When ACK_TIMEOUT != 0 and the count reaches ACK_TIMEOUT: drop dmem_req, next cycle bus_err = 1 and wb_valid = 1 with wb_rf_wen = 0, then IDLE.
  - An ack arriving in the same cycle as the timeout wins; no bus_err.
- rd = 0 is passed through unchanged; the register file ignores it.
- Reset mid-BUSY: dmem_req drops immediately (async); the in-flight access is abandoned and no wb_valid is issued.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned H/HU/SH (addr[0] = 1) or W/SW (addr[1:0] != 0) is not issued to memory; state stays IDLE.
  - Next cycle: wb_valid = 1, wb_rf_wen = 0, and extra output ma_err (1 bit) pulses 1 with extra output ma_addr (32 bits) holding the faulting address.
- Undefined: no ma_err/ma_addr ports; low address bits are ignored as described in Behaviour.

Test Plan:
- Three back-to-back non-memory ops (alu_out 0x11, 0x22, 0x33, rd 1/2/3) -> wb_valid for 3 consecutive cycles, each one cycle after its transfer, with matching data/rd; ex_ready stays 1.
- LB at addr 0x103, dmem_ack after 2 BUSY cycles, rdata 0x80FF_0000 -> dmem_addr 0x100, dmem_be 1111, ex_ready 0 during BUSY, wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
- SH at addr 0x202, rs2 0x1234_ABCD -> dmem_we 1, dmem_be 1100, dmem_wdata 0xABCD_ABCD, wb_rf_wen 0.
- ACK_TIMEOUT = 4, load with no ack -> dmem_req high for 4 cycles then low, bus_err and wb_valid pulse once, wb_rf_wen 0, next op accepted.
- rst pulsed asynchronously mid-BUSY -> dmem_req falls without a clock edge, no wb_valid; after release, an LW at 0x0 with immediate ack returns rdata.
- MISALIGN_TRAP_EN defined, LW at 0x6 -> no dmem_req, ma_err = 1, ma_addr = 0x6, wb_rf_wen = 0.
